keypad_emulator: RTL and testbench

//   Drives the 4x4 keypad column lines back into the row scanner, standing in for the

---
 rtl/keypad_emulator_if.sv | 20 ++
 rtl/keypad_emulator.sv | 204 ++++++++++++++++++++
 tb/tb_keypad_emulator.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/keypad_emulator_if.sv
// keypad_emulator_if
//   Command port of the keypad emulator: a valid/ready handshake that carries one
//   scripted key command (key code plus hold time in ticks).
//   Signals:
//     cmd_valid  master -> slave  command present
//     cmd_ready  slave  -> master emulator can accept a command this tick
//     cmd_key    master -> slave  key code 0..8, 9..15 means release (pause)
//     cmd_hold   master -> slave  press duration in ticks, 0 behaves as 1
//   HOLD_W must match the HOLD_W of the keypad_emulator the interface is bound to.
interface keypad_emulator_if #(
  parameter int HOLD_W = 8
) ();
  logic              cmd_valid;
  logic              cmd_ready;
  logic [3:0]        cmd_key;
  logic [HOLD_W-1:0] cmd_hold;

  modport master (output cmd_valid, output cmd_key, output cmd_hold, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_key, input cmd_hold, output cmd_ready);
endinterface

// File: rtl/keypad_emulator.sv
// keypad_emulator
//   Stands in for the passive 4x4 key matrix in front of a row scanner. Scripted key
//   commands are queued in a small FIFO and played one at a time: while a command is
//   pressed, the matching column is pulled low whenever its row strobe is active.
//   Every command is followed by GAP_TICKS released ticks and a one-tick done pulse.
// Ports:
//   clk_100Hz  in   100Hz tick clock
//   reset      in   asynchronous active-low reset
//   cmd        slave modport of keypad_emulator_if (valid/ready command port)
//   keypadRow  in   [3:0] active-low row strobe from the scanner
//   keypadCol  out  [3:0] active-low column lines back to the scanner
//   busy       out  a command is being played or is waiting in the FIFO
//   done       out  one-tick pulse in the idle tick that follows a command's gap
// Parameters:
//   FIFO_DEPTH command FIFO entries (power of two, >= 2)
//   HOLD_W     width of the hold field
//   GAP_TICKS  released ticks after each command (0 = none)
// Build option:
//   KEYPAD_EMU_BOUNCE_EN  when defined, the first three pressed ticks chatter
//                         (pressed, released, pressed) before the column holds solid.
module keypad_emulator #(
  parameter int FIFO_DEPTH = 4,
  parameter int HOLD_W     = 8,
  parameter int GAP_TICKS  = 4
) (
  input  logic              clk_100Hz,
  input  logic              reset,
  keypad_emulator_if.slave  cmd,
  input  logic [3:0]        keypadRow,
  output logic [3:0]        keypadCol,
  output logic              busy,
  output logic              done
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int GAP_W = (GAP_TICKS > 1) ? $clog2(GAP_TICKS + 1) : 1;

  typedef enum logic [1:0] {IDLE, PRESS, GAP} state_t;

  logic [HOLD_W+3:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wrPtr;
  logic [PTR_W-1:0]  r_rdPtr;
  logic [CNT_W-1:0]  r_count;
  state_t            r_state;
  logic [3:0]        r_key;
  logic [HOLD_W-1:0] r_cnt;
  logic [GAP_W-1:0]  r_gcnt;
  logic              r_done;

  state_t            w_stateNext;
  logic [3:0]        w_keyNext;
  logic [HOLD_W-1:0] w_cntNext;
  logic [GAP_W-1:0]  w_gcntNext;
  logic              w_doneNext;
  logic              w_pop;
  logic              w_push;
  logic              w_full;
  logic              w_empty;
  logic [HOLD_W+3:0] w_head;
  logic [3:0]        w_headKey;
  logic [HOLD_W-1:0] w_headHold;
  logic [3:0]        w_rowMatch;
  logic [3:0]        w_colDrive;
  logic              w_keyValid;
  logic              w_chatterOff;

  // The occupancy counter is one bit wider than the pointers so full and empty
  // stay distinguishable; ready comes from the registered count, so a pop in the
  // same tick never makes room for that tick's push.
  assign w_full        = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_empty       = (r_count == '0);
  assign w_push        = cmd.cmd_valid && !w_full;
  assign cmd.cmd_ready = !w_full;
  assign w_head        = r_mem[r_rdPtr];
  assign w_headKey     = w_head[HOLD_W+3:HOLD_W];
  assign w_headHold    = w_head[HOLD_W-1:0];
  assign busy          = (r_state != IDLE) || !w_empty;
  assign done          = r_done;

  // FIFO storage carries no reset; only the pointers and count define its contents.
  always_ff @(posedge clk_100Hz) begin
    if (w_push) begin
      r_mem[r_wrPtr] <= {cmd.cmd_key, cmd.cmd_hold};
    end
  end

  // State, counters and FIFO bookkeeping; reset flushes the queue and aborts any press.
  always_ff @(posedge clk_100Hz or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_key   <= 4'hF;
      r_cnt   <= '0;
      r_gcnt  <= '0;
      r_done  <= 1'b0;
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      r_state <= w_stateNext;
      r_key   <= w_keyNext;
      r_cnt   <= w_cntNext;
      r_gcnt  <= w_gcntNext;
      r_done  <= w_doneNext;
      if (w_push) begin
        r_wrPtr <= r_wrPtr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + PTR_W'(1);
      end
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

  // Player sequencing. IDLE is always visited for one tick between commands, and
  // the done pulse is registered so it shows up during that idle tick.
  always_comb begin
    w_stateNext = r_state;
    w_keyNext   = r_key;
    w_cntNext   = r_cnt;
    w_gcntNext  = r_gcnt;
    w_doneNext  = 1'b0;
    w_pop       = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_keyNext   = w_headKey;
          w_cntNext   = (w_headHold == '0) ? HOLD_W'(1) : w_headHold;
          w_stateNext = PRESS;
        end
      end
      PRESS: begin
        if (r_cnt == HOLD_W'(1)) begin
          if (GAP_TICKS == 0) begin
            w_stateNext = IDLE;
            w_doneNext  = 1'b1;
          end else begin
            w_stateNext = GAP;
            w_gcntNext  = GAP_W'(GAP_TICKS);
          end
        end else begin
          w_cntNext = r_cnt - HOLD_W'(1);
        end
      end
      GAP: begin
        if (r_gcnt == GAP_W'(1)) begin
          w_stateNext = IDLE;
          w_doneNext  = 1'b1;
        end else begin
          w_gcntNext = r_gcnt - GAP_W'(1);
        end
      end
      default: begin
        w_stateNext = IDLE;
      end
    endcase
  end

`ifdef KEYPAD_EMU_BOUNCE_EN
  logic [1:0] r_pressIdx;

  // Counts pressed ticks (saturating) so the second pressed tick can read released.
  always_ff @(posedge clk_100Hz or negedge reset) begin
    if (!reset) begin
      r_pressIdx <= '0;
    end else if (r_state != PRESS) begin
      r_pressIdx <= '0;
    end else if (r_pressIdx != 2'd3) begin
      r_pressIdx <= r_pressIdx + 2'd1;
    end
  end

  assign w_chatterOff = (r_state == PRESS) && (r_pressIdx == 2'd1);
`else
  assign w_chatterOff = 1'b0;
`endif

  // Key matrix: keys 0..8 laid out three per row on the top three rows/columns.
  // The column follows the row strobe combinationally, just like a real switch.
  always_comb begin
    w_rowMatch = 4'b1111;
    w_colDrive = 4'b1111;
    w_keyValid = (r_key <= 4'd8);
    case (r_key)
      4'd0, 4'd1, 4'd2: w_rowMatch = 4'b0111;
      4'd3, 4'd4, 4'd5: w_rowMatch = 4'b1011;
      4'd6, 4'd7, 4'd8: w_rowMatch = 4'b1101;
      default:          w_rowMatch = 4'b1111;
    endcase
    case (r_key)
      4'd0, 4'd3, 4'd6: w_colDrive = 4'b0111;
      4'd1, 4'd4, 4'd7: w_colDrive = 4'b1011;
      4'd2, 4'd5, 4'd8: w_colDrive = 4'b1101;
      default:          w_colDrive = 4'b1111;
    endcase
    if ((r_state == PRESS) && w_keyValid && !w_chatterOff && (keypadRow == w_rowMatch)) begin
      keypadCol = w_colDrive;
    end else begin
      keypadCol = 4'b1111;
    end
  end

endmodule

// File: tb/tb_keypad_emulator.sv
// tb_keypad_emulator
//   Scoreboard bench for keypad_emulator. Each accepted command is scheduled by a
//   timeline model (start tick, press length, done tick) and its done tick is queued;
//   a monitor running on the falling edge compares columns, ready and busy against
//   the timeline every tick and pops the done queue whenever the DUT pulses done.
module tb_keypad_emulator;

  localparam int DEPTH  = 4;
  localparam int HOLD_W = 8;
  localparam int GAP    = 4;

  typedef struct {
    int key;
    int len;
    int push;
    int start;
    int doneSlot;
  } cmd_t;

  logic       clk;
  logic       reset;
  logic [3:0] keypadRow;
  logic [3:0] keypadCol;
  logic       busy;
  logic       done;

  cmd_t sched[$];
  int   expDone[$];
  int   freeSlot = 0;
  int   curSlot  = -1;
  int   nChecks  = 0;
  int   nErrors  = 0;
  int   rowMode  = 0;

  keypad_emulator_if #(.HOLD_W(HOLD_W)) cmdIf ();

  keypad_emulator #(
    .FIFO_DEPTH (DEPTH),
    .HOLD_W     (HOLD_W),
    .GAP_TICKS  (GAP)
  ) dut (
    .clk_100Hz (clk),
    .reset     (reset),
    .cmd       (cmdIf.slave),
    .keypadRow (keypadRow),
    .keypadCol (keypadCol),
    .busy      (busy),
    .done      (done)
  );

  // 10-unit tick clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case the bench itself gets stuck.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, checks=%0d", nChecks);
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nErrors++;
      $display("[TB] FAIL %s at slot %0d: got %0h, expected %0h", name, curSlot, actual, expected);
    end
  endtask

  // Commands waiting in the FIFO at slot s: pushed by then, not yet started.
  function automatic int modelCount(input int s);
    int n = 0;
    foreach (sched[i]) begin
      if (sched[i].push <= s && s < sched[i].start) n++;
    end
    return n;
  endfunction

  function automatic logic modelBusy(input int s);
    if (modelCount(s) > 0) return 1'b1;
    foreach (sched[i]) begin
      if (sched[i].start <= s && s < sched[i].doneSlot) return 1'b1;
    end
    return 1'b0;
  endfunction

  // Key k sits on row k/3 and column k%3; row/column index i is the line with bit 3-i low.
  function automatic logic [3:0] modelCol(input int s, input logic [3:0] row);
    logic [3:0] expRow;
    logic [3:0] expCol;
    foreach (sched[i]) begin
      if (sched[i].start <= s && s < sched[i].start + sched[i].len && sched[i].key <= 8) begin
`ifdef KEYPAD_EMU_BOUNCE_EN
        if (s - sched[i].start == 1) return 4'b1111;
`endif
        expRow = 4'b1111;
        expCol = 4'b1111;
        expRow[3 - sched[i].key / 3] = 1'b0;
        expCol[3 - sched[i].key % 3] = 1'b0;
        if (row == expRow) return expCol;
      end
    end
    return 4'b1111;
  endfunction

  // A command becomes playable the slot it is pushed; playback starts the tick after
  // the player is idle with it available.
  task automatic recordCmd(input int key, input int hold, input int push);
    cmd_t c;
    int   len;
    int   st;
    len = (hold == 0) ? 1 : hold;
    st  = ((push > freeSlot) ? push : freeSlot) + 1;
    c.key      = key;
    c.len      = len;
    c.push     = push;
    c.start    = st;
    c.doneSlot = st + len + GAP;
    sched.push_back(c);
    expDone.push_back(c.doneSlot);
    freeSlot = c.doneSlot;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called just after a rising edge; offers the command until the model says it is taken.
  task automatic applyStimulus(input int key, input int hold, input bit keepValid);
    int  e;
    int  tries;
    bit  accepted;
    tries    = 0;
    accepted = 1'b0;
    while (!accepted) begin
      e = curSlot + 1;
      cmdIf.cmd_valid = 1'b1;
      cmdIf.cmd_key   = key[3:0];
      cmdIf.cmd_hold  = hold[HOLD_W-1:0];
      accepted = (modelCount(e) < DEPTH);
      if (accepted) recordCmd(key, hold, e + 1);
      tick(1);
      tries++;
      if (!accepted && tries > 2000) begin
        nChecks++;
        nErrors++;
        $display("[TB] FAIL accept_timeout: key %0d not accepted after %0d ticks", key, tries);
        accepted = 1'b1;
      end
    end
    if (!keepValid) cmdIf.cmd_valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (expDone.size() > 0 && n < budget) begin
      tick(1);
      n++;
    end
    if (expDone.size() > 0) begin
      nChecks++;
      nErrors++;
      $display("[TB] FAIL drain_timeout: %0d done pulses outstanding, expected 0", expDone.size());
      expDone.delete();
    end
  endtask

  // Row scanner stand-in: rotating strobe, random values, or a fixed row.
  initial begin
    int idx;
    logic [3:0] r;
    idx = 0;
    keypadRow = 4'b0111;
    forever begin
      @(posedge clk);
      #1;
      case (rowMode)
        0: begin
          r = 4'b1111;
          r[3 - idx] = 1'b0;
          keypadRow = r;
          idx = (idx + 1) % 4;
        end
        1: keypadRow = 4'($urandom);
        default: keypadRow = 4'b0111;
      endcase
    end
  end

  // Monitor: every falling edge compares outputs to the timeline and pops the
  // done scoreboard whenever the DUT presents a done pulse.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        curSlot = -1;
        checkOutput("rst_col", keypadCol, 4'b1111);
        checkOutput("rst_ready", cmdIf.cmd_ready, 1'b1);
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_done", done, 1'b0);
      end else begin
        curSlot++;
        checkOutput("col", keypadCol, modelCol(curSlot, keypadRow));
        checkOutput("ready", cmdIf.cmd_ready, (modelCount(curSlot) < DEPTH));
        checkOutput("busy", busy, modelBusy(curSlot));
        if (done) begin
          if (expDone.size() == 0) begin
            nChecks++;
            nErrors++;
            $display("[TB] FAIL done_unexpected at slot %0d: got done=1, expected done=0", curSlot);
          end else begin
            checkOutput("done_slot", curSlot, expDone.pop_front());
          end
        end else if (expDone.size() > 0 && expDone[0] <= curSlot) begin
          nChecks++;
          nErrors++;
          $display("[TB] FAIL done_missing at slot %0d: got done=0, expected pulse at slot %0d", curSlot, expDone[0]);
          void'(expDone.pop_front());
        end
      end
    end
  end

  initial begin
    int gap;
    reset           = 1'b0;
    cmdIf.cmd_valid = 1'b0;
    cmdIf.cmd_key   = 4'h0;
    cmdIf.cmd_hold  = '0;
    tick(3);
    reset = 1'b1;
    tick(2);

    $display("[TB] single key 4, hold 8, rotating rows");
    rowMode = 0;
    applyStimulus(4, 8, 1'b0);
    drain(100);
    tick(2);

    $display("[TB] keys 0,5,8 back-to-back");
    applyStimulus(0, 2, 1'b1);
    applyStimulus(5, 2, 1'b1);
    applyStimulus(8, 2, 1'b0);
    drain(200);
    tick(2);

    $display("[TB] FIFO fill behind a long press");
    applyStimulus(2, 200, 1'b0);
    tick(3);
    for (int i = 0; i < 5; i++) applyStimulus(i + 3, 1, 1'b1);
    cmdIf.cmd_valid = 1'b0;
    drain(600);
    tick(2);

    $display("[TB] release command and zero hold");
    rowMode = 1;
    applyStimulus(12, 5, 1'b0);
    applyStimulus(3, 0, 1'b0);
    drain(100);
    tick(2);

    $display("[TB] reset during press");
    applyStimulus(7, 50, 1'b0);
    applyStimulus(1, 3, 1'b0);
    applyStimulus(2, 3, 1'b0);
    tick(8);
    reset = 1'b0;
    sched.delete();
    expDone.delete();
    freeSlot = 0;
    #1;
    checkOutput("async_rst_col", keypadCol, 4'b1111);
    checkOutput("async_rst_busy", busy, 1'b0);
    checkOutput("async_rst_ready", cmdIf.cmd_ready, 1'b1);
    tick(2);
    reset = 1'b1;
    tick(3);
    applyStimulus(6, 2, 1'b0);
    drain(100);
    tick(2);

    $display("[TB] fixed row, key 1 hold 6");
    rowMode = 2;
    applyStimulus(1, 6, 1'b0);
    drain(100);
    tick(2);

    $display("[TB] randomized commands");
    for (int i = 0; i < 40; i++) begin
      rowMode = (i % 3 == 2) ? 1 : 0;
      gap = $urandom_range(0, 3);
      applyStimulus($urandom_range(0, 15), $urandom_range(0, 6), (gap == 0));
      if (gap > 0) tick(gap);
    end
    cmdIf.cmd_valid = 1'b0;
    drain(2000);
    tick(3);

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
